tick_driven_bcd_timer: RTL
==========================

Name: tick_driven_bcd_timer

Overview:
Downstream consumer of the single-cycle periodic tick produced by the regular-pulse generator (one pulse every 20 clk cycles). It divides ticks by a prescale and runs an MM:SS BCD up-counter under a start/pause/clear FSM. When the count reaches a target latched at start, it flags completion. Its outputs drive 7-segment display logic and status LEDs.

Parameters:
TICKS_PER_SEC, 1, ticks per seconds increment; legal range 1..255; 8-bit internal prescaler.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
tick  input  1  single-cycle pulse from upstream periodic pulse generator
start  input  1  single-cycle command: IDLE/PAUSE/DONE -> RUN
pause  input  1  single-cycle command: RUN -> PAUSE
clear  input  1  single-cycle command: any state -> IDLE, count zeroed
target  input  14  BCD target {m_tens[13:11], m_ones[10:7], s_tens[6:4], s_ones[3:0]}
sec_ones  output  4  BCD seconds ones, 0..9
sec_tens  output  3  BCD seconds tens, 0..5
min_ones  output  4  BCD minutes ones, 0..9
min_tens  output  3  BCD minutes tens, 0..5
state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3
done  output  1  level; high while in DONE
alarm  output  1  single-cycle pulse on the edge entering DONE
wrap  output  1  single-cycle pulse when count rolls 59:59 -> 00:00

Behaviour:
- Reset (async, rst_n low): state=IDLE, all digits 0, prescaler 0, target register 0, done=0, alarm=0, wrap=0. Release is synchronous to clk by construction.
- All outputs are registered. No combinational path from inputs to outputs.
- Command priority in the same cycle: clear > pause > start. Lower-priority commands are ignored.
- clear: next state IDLE; digits, prescaler and done go to 0; the target register holds its value.
- start from IDLE or DONE: latch target, zero digits and prescaler, go to RUN.
- start from PAUSE: go to RUN with count, prescaler and target retained.
- start while in RUN: ignored.
- pause in RUN: go to PAUSE. pause in any other state: ignored.
- Ticks count only while the state register equals RUN. A tick coinciding with start is not counted. A tick coinciding with pause or clear is not counted.
- Prescaler in RUN:
  - On a tick with prescaler == TICKS_PER_SEC-1: prescaler <= 0 and the count increments.
  - On any other tick: prescaler increments.
  - With TICKS_PER_SEC=1, every tick increments the count.
- Count increment (one edge, digits updated together):
  - sec_ones 9 -> 0 carries into sec_tens.
  - sec_tens 5 -> 0 carries into min_ones.
  - min_ones 9 -> 0 carries into min_tens.
  - min_tens 5 -> 0 pulses wrap in the same cycle the count reads 00:00.
- Target match: compare the post-increment value against the latched target.
  - On a match: state <= DONE, and alarm=1 for exactly one cycle, coincident with the digits first showing the target.
  - done rises on the same edge and stays high until clear or start.
- Target 00:00: wrap does not cause a match, so the timer free-runs and wrap pulses every 3600 seconds.
- Target with an illegal BCD digit (ones >9, tens >5): never matches, so the timer free-runs.
- DONE: ticks are ignored and the count is frozen at the target.
- PAUSE: count and prescaler are frozen; ticks are ignored.
- Reset mid-operation: immediate return to the reset values above, including a cancelled alarm or wrap pulse.
- Latency: count digits change on the clk edge that samples the qualifying tick, i.e. one cycle after tick is seen high.

Test Plan:
- Reset, TICKS_PER_SEC=1, target=00:05, start, upstream tick every 20 cycles -> digits 00:01..00:05; alarm high one cycle at count 00:05 (~100 cycles after start); done=1; further ticks leave 00:05.
- Count 00:59 then one tick -> 01:00 in one edge. Preload to 59:59 via free-run target 00:00, then one tick -> 00:00, wrap=1 for one cycle, state stays RUN.
- TICKS_PER_SEC=4: 7 ticks after start -> 00:01 with prescaler 3. Pause, 5 ticks, start, 1 tick -> 00:02.
- Same-cycle collisions: tick+start from IDLE -> 00:00. tick+pause in RUN at 00:03 -> stays 00:03, state PAUSE. clear+start -> IDLE, 00:00. pause+start in RUN -> PAUSE.
- start in DONE at 00:05 with new target 00:02 -> count 00:00, RUN, done=0; alarm after 2 ticks.
- rst_n low asynchronously mid-RUN at 00:03 (between clk edges) -> outputs 0/IDLE immediately. Illegal target 00:0A -> no alarm after 70 ticks, count 01:10.

Source files
------------

// File: rtl/tick_driven_bcd_timer.sv
// MM:SS BCD up-timer advanced by an upstream periodic tick.
// Start/pause/clear FSM with a target latched at start and a done/alarm flag.
module tick_driven_bcd_timer #(
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  input  logic [13:0] target,
  output logic [3:0]  sec_ones,
  output logic [2:0]  sec_tens,
  output logic [3:0]  min_ones,
  output logic [2:0]  min_tens,
  output logic [1:0]  state,
  output logic        done,
  output logic        alarm,
  output logic        wrap
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0] P_LAST = 8'(TICKS_PER_SEC - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_n;
  logic [7:0]  r_presc;
  logic [7:0]  w_presc_n;
  logic [3:0]  r_so;
  logic [3:0]  w_so_n;
  logic [2:0]  r_st;
  logic [2:0]  w_st_n;
  logic [3:0]  r_mo;
  logic [3:0]  w_mo_n;
  logic [2:0]  r_mt;
  logic [2:0]  w_mt_n;
  logic [13:0] r_tgt;
  logic [13:0] w_tgt_n;
  logic        r_done;
  logic        w_done_n;
  logic        r_alarm;
  logic        w_alarm_n;
  logic        r_wrap;
  logic        w_wrap_n;

  logic        w_is_run;
  logic        w_do_pause;
  logic        w_do_start;
  logic        w_tick_ok;
  logic        w_sec_step;
  logic        w_presc_step;

  logic        w_c0;
  logic        w_c1;
  logic        w_c2;
  logic        w_c3;
  logic [3:0]  w_inc_so;
  logic [2:0]  w_inc_st;
  logic [3:0]  w_inc_mo;
  logic [2:0]  w_inc_mt;
  logic        w_match;

  // Commands decoded with clear > pause > start priority.
  assign w_is_run     = (r_state == S_RUN);
  assign w_do_pause   = pause & ~clear & w_is_run;
  assign w_do_start   = start & ~clear & ~pause & ~w_is_run;
  assign w_tick_ok    = tick & w_is_run & ~clear & ~pause;
  assign w_sec_step   = w_tick_ok & (r_presc == P_LAST);
  assign w_presc_step = w_tick_ok & (r_presc != P_LAST);

  assign w_c0 = (r_so == 4'd9);
  assign w_c1 = w_c0 & (r_st == 3'd5);
  assign w_c2 = w_c1 & (r_mo == 4'd9);
  assign w_c3 = w_c2 & (r_mt == 3'd5);

  assign w_inc_so = w_c0 ? 4'd0 : r_so + 4'd1;
  assign w_inc_st = w_c0 ? (w_c1 ? 3'd0 : r_st + 3'd1) : r_st;
  assign w_inc_mo = w_c1 ? (w_c2 ? 4'd0 : r_mo + 4'd1) : r_mo;
  assign w_inc_mt = w_c2 ? (w_c3 ? 3'd0 : r_mt + 3'd1) : r_mt;

  // A rollover to 00:00 never counts as reaching the target.
  assign w_match = ~w_c3 &
    ({w_inc_mt, w_inc_mo, w_inc_st, w_inc_so} == r_tgt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    unique case (1'b1)
      clear:                  w_state_n = S_IDLE;
      w_do_pause:             w_state_n = S_PAUSE;
      w_do_start:             w_state_n = S_RUN;
      (w_sec_step & w_match): w_state_n = S_DONE;
      default:                w_state_n = r_state;
    endcase
  end

  always_comb begin
    w_presc_n = r_presc;
    w_so_n    = r_so;
    w_st_n    = r_st;
    w_mo_n    = r_mo;
    w_mt_n    = r_mt;
    w_tgt_n   = r_tgt;
    w_alarm_n = 1'b0;
    w_wrap_n  = 1'b0;
    unique case (1'b1)
      clear: begin
        w_presc_n = 8'd0;
        w_so_n    = 4'd0;
        w_st_n    = 3'd0;
        w_mo_n    = 4'd0;
        w_mt_n    = 3'd0;
      end
      w_do_start: begin
        if (r_state != S_PAUSE) begin
          w_presc_n = 8'd0;
          w_so_n    = 4'd0;
          w_st_n    = 3'd0;
          w_mo_n    = 4'd0;
          w_mt_n    = 3'd0;
          w_tgt_n   = target;
        end
      end
      w_sec_step: begin
        w_presc_n = 8'd0;
        w_so_n    = w_inc_so;
        w_st_n    = w_inc_st;
        w_mo_n    = w_inc_mo;
        w_mt_n    = w_inc_mt;
        w_alarm_n = w_match;
        w_wrap_n  = w_c3;
      end
      w_presc_step: begin
        w_presc_n = r_presc + 8'd1;
      end
      default: begin
        w_presc_n = r_presc;
      end
    endcase
  end

  assign w_done_n = (w_state_n == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= 8'd0;
      r_so    <= 4'd0;
      r_st    <= 3'd0;
      r_mo    <= 4'd0;
      r_mt    <= 3'd0;
      r_tgt   <= 14'd0;
      r_done  <= 1'b0;
      r_alarm <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_presc <= w_presc_n;
      r_so    <= w_so_n;
      r_st    <= w_st_n;
      r_mo    <= w_mo_n;
      r_mt    <= w_mt_n;
      r_tgt   <= w_tgt_n;
      r_done  <= w_done_n;
      r_alarm <= w_alarm_n;
      r_wrap  <= w_wrap_n;
    end
  end

  assign sec_ones = r_so;
  assign sec_tens = r_st;
  assign min_ones = r_mo;
  assign min_tens = r_mt;
  assign state    = r_state;
  assign done     = r_done;
  assign alarm    = r_alarm;
  assign wrap     = r_wrap;

endmodule
